// File: rtl/wb_regfile.sv
// Writeback-stage register file: 16 x 8-bit registers with R0 hardwired to zero,
// plus a commit pulse and a saturating commit counter. Define WB_REGFILE_BYPASS_EN for write-to-read bypass.
module wb_regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [3:0]  iwb_addr,
  input  logic [7:0]  iwb_mem_data,
  input  logic [7:0]  iwb_alu_out,
  input  logic        iwb_write_en,
  input  logic        iwb_mem_to_reg,
  input  logic [3:0]  ira_addr,
  input  logic [3:0]  irb_addr,
  output logic [7:0]  ora_data,
  output logic [7:0]  orb_data,
  output logic [7:0]  owb_data,
  output logic        owb_commit,
  output logic [15:0] owb_count
);

  logic [7:0]  regs_q [16];
  logic [7:0]  regs_d [16];
  logic        commit_q, commit_d;
  logic [15:0] count_q, count_d;
  logic        wb_fire;

  assign owb_data = iwb_mem_to_reg ? iwb_mem_data : iwb_alu_out;
  assign wb_fire  = en && iwb_write_en && (iwb_addr != 4'd0);

  always_comb begin
    regs_d   = regs_q;
    commit_d = wb_fire;
    count_d  = count_q;
    if (wb_fire) begin
      regs_d[iwb_addr] = owb_data;
      if (count_q != 16'hFFFF) begin
        count_d = count_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) begin
        regs_q[i] <= 8'h00;
      end
      commit_q <= 1'b0;
      count_q  <= 16'h0000;
    end else begin
      regs_q   <= regs_d;
      commit_q <= commit_d;
      count_q  <= count_d;
    end
  end

  // R0 is forced to zero on read so it never depends on the stored slot.
  function automatic logic [7:0] read_port(input logic [3:0] addr);
    logic [7:0] value;
    value = (addr == 4'd0) ? 8'h00 : regs_q[addr];
`ifdef WB_REGFILE_BYPASS_EN
    if (wb_fire && (addr == iwb_addr)) begin
      value = owb_data;
    end
`endif
    return value;
  endfunction

  assign ora_data   = read_port(ira_addr);
  assign orb_data   = read_port(irb_addr);
  assign owb_commit = commit_q;
  assign owb_count  = count_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed self-checking bench for wb_regfile; inputs change and outputs are
// sampled on the falling clock edge, away from the active rising edge.
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [3:0]  iwb_addr;
  logic [7:0]  iwb_mem_data;
  logic [7:0]  iwb_alu_out;
  logic        iwb_write_en;
  logic        iwb_mem_to_reg;
  logic [3:0]  ira_addr;
  logic [3:0]  irb_addr;
  logic [7:0]  ora_data;
  logic [7:0]  orb_data;
  logic [7:0]  owb_data;
  logic        owb_commit;
  logic [15:0] owb_count;

  int checks = 0;
  int errors = 0;

  wb_regfile dut (
    .clk            (clk),
    .rst            (rst),
    .en             (en),
    .iwb_addr       (iwb_addr),
    .iwb_mem_data   (iwb_mem_data),
    .iwb_alu_out    (iwb_alu_out),
    .iwb_write_en   (iwb_write_en),
    .iwb_mem_to_reg (iwb_mem_to_reg),
    .ira_addr       (ira_addr),
    .irb_addr       (irb_addr),
    .ora_data       (ora_data),
    .orb_data       (orb_data),
    .owb_data       (owb_data),
    .owb_commit     (owb_commit),
    .owb_count      (owb_count)
  );

  always #5 clk = ~clk;

  task automatic applyStimulus(input logic e, input logic wen, input logic [3:0] addr,
                               input logic m2r, input logic [7:0] mem, input logic [7:0] alu);
    en             = e;
    iwb_write_en   = wen;
    iwb_addr       = addr;
    iwb_mem_to_reg = m2r;
    iwb_mem_data   = mem;
    iwb_alu_out    = alu;
  endtask

  task automatic applyIdle();
    applyStimulus(1'b1, 1'b0, 4'd0, 1'b0, 8'h00, 8'h00);
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Advance through one rising edge, then drop to idle inputs before sampling.
  task automatic stepThenIdle();
    @(posedge clk);
    @(negedge clk);
    applyIdle();
    #1;
  endtask

  initial begin
    rst = 1'b1;
    ira_addr = 4'd0;
    irb_addr = 4'd0;
    applyIdle();
    #12;

    for (int i = 0; i < 16; i++) begin
      ira_addr = 4'(i);
      irb_addr = 4'(15 - i);
      #1;
      checkOutput($sformatf("reset_ra_r%0d", i), {8'h00, ora_data}, 16'h0000);
      checkOutput($sformatf("reset_rb_r%0d", 15 - i), {8'h00, orb_data}, 16'h0000);
    end
    checkOutput("reset_count", owb_count, 16'h0000);
    checkOutput("reset_commit", {15'd0, owb_commit}, 16'h0000);

    @(negedge clk);
    rst = 1'b0;

    // Basic ALU-sourced write to R5
    @(negedge clk);
    applyStimulus(1'b1, 1'b1, 4'd5, 1'b0, 8'hEE, 8'h3C);
    ira_addr = 4'd5;
    #1;
    checkOutput("wbdata_alu", {8'h00, owb_data}, 16'h003C);
    stepThenIdle();
    checkOutput("r5_after_write", {8'h00, ora_data}, 16'h003C);
    checkOutput("commit_after_r5", {15'd0, owb_commit}, 16'h0001);
    checkOutput("count_after_r5", owb_count, 16'h0001);
    stepThenIdle();
    checkOutput("commit_drops", {15'd0, owb_commit}, 16'h0000);
    checkOutput("count_holds", owb_count, 16'h0001);

    // Write to R0 is discarded
    applyStimulus(1'b1, 1'b1, 4'd0, 1'b1, 8'hFF, 8'h12);
    ira_addr = 4'd0;
    #1;
    checkOutput("wbdata_mem", {8'h00, owb_data}, 16'h00FF);
    checkOutput("r0_pending", {8'h00, ora_data}, 16'h0000);
    stepThenIdle();
    checkOutput("r0_after", {8'h00, ora_data}, 16'h0000);
    checkOutput("commit_r0", {15'd0, owb_commit}, 16'h0000);
    checkOutput("count_r0", owb_count, 16'h0001);

    // en=0 blocks the write, then en=1 lets it through
    applyStimulus(1'b0, 1'b1, 4'd7, 1'b0, 8'h00, 8'hA5);
    ira_addr = 4'd7;
    #1;
    checkOutput("wbdata_en0", {8'h00, owb_data}, 16'h00A5);
    checkOutput("r7_en0_pending", {8'h00, ora_data}, 16'h0000);
    stepThenIdle();
    checkOutput("r7_en0", {8'h00, ora_data}, 16'h0000);
    checkOutput("commit_en0", {15'd0, owb_commit}, 16'h0000);
    checkOutput("count_en0", owb_count, 16'h0001);
    applyStimulus(1'b1, 1'b1, 4'd7, 1'b0, 8'h00, 8'hA5);
    stepThenIdle();
    checkOutput("r7_en1", {8'h00, ora_data}, 16'h00A5);
    checkOutput("commit_en1", {15'd0, owb_commit}, 16'h0001);
    checkOutput("count_en1", owb_count, 16'h0002);

    irb_addr = 4'd7;
    #1;
    checkOutput("same_addr_ra", {8'h00, ora_data}, 16'h00A5);
    checkOutput("same_addr_rb", {8'h00, orb_data}, 16'h00A5);

    // Pending write to R3: visible early only with bypass
    applyStimulus(1'b1, 1'b1, 4'd3, 1'b0, 8'h00, 8'h42);
    ira_addr = 4'd3;
    irb_addr = 4'd3;
    #1;
`ifdef WB_REGFILE_BYPASS_EN
    checkOutput("r3_pending_ra", {8'h00, ora_data}, 16'h0042);
    checkOutput("r3_pending_rb", {8'h00, orb_data}, 16'h0042);
`else
    checkOutput("r3_pending_ra", {8'h00, ora_data}, 16'h0000);
    checkOutput("r3_pending_rb", {8'h00, orb_data}, 16'h0000);
`endif
    stepThenIdle();
    checkOutput("r3_after", {8'h00, ora_data}, 16'h0042);
    checkOutput("count_r3", owb_count, 16'h0003);

    // Memory-sourced write to R9
    applyStimulus(1'b1, 1'b1, 4'd9, 1'b1, 8'h77, 8'h11);
    stepThenIdle();
    ira_addr = 4'd9;
    irb_addr = 4'd5;
    #1;
    checkOutput("r9_mem", {8'h00, ora_data}, 16'h0077);
    checkOutput("r5_kept", {8'h00, orb_data}, 16'h003C);
    checkOutput("count_r9", owb_count, 16'h0004);

    // Reset with a write pending: nothing commits while rst is high
    applyStimulus(1'b1, 1'b1, 4'd4, 1'b0, 8'h00, 8'h99);
    ira_addr = 4'd5;
    irb_addr = 4'd9;
    rst = 1'b1;
    #1;
    checkOutput("rst_clears_r5", {8'h00, ora_data}, 16'h0000);
    checkOutput("rst_clears_r9", {8'h00, orb_data}, 16'h0000);
    checkOutput("rst_clears_count", owb_count, 16'h0000);
    checkOutput("rst_clears_commit", {15'd0, owb_commit}, 16'h0000);
    @(posedge clk);
    @(negedge clk);
    #1;
    checkOutput("rst_no_commit_count", owb_count, 16'h0000);
    checkOutput("rst_no_commit_pulse", {15'd0, owb_commit}, 16'h0000);
    rst = 1'b0;
    stepThenIdle();
    ira_addr = 4'd4;
    #1;
    checkOutput("r4_after_release", {8'h00, ora_data}, 16'h0099);
    checkOutput("commit_after_release", {15'd0, owb_commit}, 16'h0001);
    checkOutput("count_after_release", owb_count, 16'h0001);

    // Drive the counter to 0xFFFE, then saturate
    @(negedge clk);
    rst = 1'b1;
    #1;
    rst = 1'b0;
    applyStimulus(1'b1, 1'b1, 4'd1, 1'b0, 8'h00, 8'h5A);
    repeat (65534) @(posedge clk);
    @(negedge clk);
    #1;
    checkOutput("count_preload", owb_count, 16'hFFFE);
    @(negedge clk);
    #1;
    checkOutput("count_sat_1", owb_count, 16'hFFFF);
    @(negedge clk);
    @(negedge clk);
    #1;
    checkOutput("count_sat_3", owb_count, 16'hFFFF);
    checkOutput("commit_while_sat", {15'd0, owb_commit}, 16'h0001);

    // Mid-cycle reset clears everything immediately
    applyIdle();
    ira_addr = 4'd1;
    #2;
    rst = 1'b1;
    #1;
    checkOutput("midrst_count", owb_count, 16'h0000);
    checkOutput("midrst_r1", {8'h00, ora_data}, 16'h0000);
    checkOutput("midrst_commit", {15'd0, owb_commit}, 16'h0000);
    @(negedge clk);
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_regfile.md
WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 clk  input  1  Single clock; all state updates on its rising edge.
REQ-002 rst  input  1  Reset, asynchronous, active-high.
REQ-003 en  input  1  Writeback enable; when 0, no architectural write and no counter update occur.
REQ-004 iwb_addr  input  4  Destination register index from the MEM/WB stage.
REQ-005 iwb_mem_data  input  8  Memory load data from the MEM/WB stage.
REQ-006 iwb_alu_out  input  8  ALU result from the MEM/WB stage.
REQ-007 iwb_write_en  input  1  Write request from the MEM/WB stage.
REQ-008 iwb_mem_to_reg  input  1  Source select: 1 selects iwb_mem_data, 0 selects iwb_alu_out.
REQ-009 ira_addr  input  4  Read port A index.
REQ-010 irb_addr  input  4  Read port B index.
REQ-011 ora_data  output  8  Read port A data, combinational.
REQ-012 orb_data  output  8  Read port B data, combinational.
REQ-013 owb_data  output  8  Selected writeback value, combinational, for EX-stage forwarding.
REQ-014 owb_commit  output  1  Registered pulse, high for the cycle after a write commits.
REQ-015 owb_count  output  16  Count of committed writes, saturating.

Function
REQ-016 Storage SHALL be 16 registers of 8 bits each, R0..R15.
REQ-017 owb_data SHALL equal iwb_mem_data when iwb_mem_to_reg=1, otherwise iwb_alu_out, regardless of en or iwb_write_en.
REQ-018 A write SHALL commit on a rising clk edge iff en=1, iwb_write_en=1 and iwb_addr!=0; R[iwb_addr] then takes owb_data.
REQ-019 R0 SHALL always read 0x00; a write targeting R0 SHALL be discarded and SHALL NOT count as a commit.
REQ-020 Read ports SHALL be combinational: ora_data=R[ira_addr] and orb_data=R[irb_addr], both subject to REQ-019 and REQ-029.
REQ-021 owb_commit SHALL be 1 in the cycle following a commit edge, otherwise 0; latency is exactly one cycle.
REQ-022 owb_count SHALL increment by 1 per commit and SHALL hold at 0xFFFF without wrapping.
REQ-023 When en=0, all registers, owb_count and pending inputs SHALL be ignored; owb_commit SHALL be 0 on the next cycle.
REQ-024 When both read ports address the same register, they SHALL return identical data.

Reset
REQ-025 Asserting rst SHALL immediately clear R1..R15 to 0x00, owb_commit to 0 and owb_count to 0x0000, independent of clk.
REQ-026 No write SHALL commit on any clk edge while rst=1; a write presented in the same cycle rst is released SHALL commit on the first edge with rst=0.
REQ-027 Assertion of rst in mid-operation SHALL discard any in-flight write without partial update.

Configuration
REQ-028 The macro WB_REGFILE_BYPASS_EN SHALL control same-cycle write-to-read bypass.
REQ-029 With WB_REGFILE_BYPASS_EN defined, a read port whose address equals iwb_addr (nonzero) while en=1 and iwb_write_en=1 SHALL return owb_data in that same cycle.
REQ-030 Without WB_REGFILE_BYPASS_EN, read ports SHALL return the stored value, so the new value becomes visible only after the commit edge.

Verification
REQ-031 Reset then read all 16 indices -> all reads 0x00, owb_count=0x0000, owb_commit=0.
REQ-032 en=1, write_en=1, addr=5, mem_to_reg=0, alu_out=0x3C -> after the edge, R5 reads 0x3C, owb_commit=1 for one cycle, owb_count=1.
REQ-033 addr=0, write_en=1, mem_data=0xFF, mem_to_reg=1 -> R0 reads 0x00, owb_commit=0, owb_count unchanged.
REQ-034 addr=7 write of 0xA5 with en=0 -> R7 is unchanged and owb_count is unchanged; repeat with en=1 -> R7=0xA5.
REQ-035 ira_addr=3 with a pending write of 0x42 to R3 -> ora_data=0x42 before the edge if WB_REGFILE_BYPASS_EN is defined, otherwise the old value until after the edge.
REQ-036 Preload owb_count to 0xFFFE, then perform 3 commits -> owb_count=0xFFFF; assert rst mid-sequence -> immediate 0x0000.
